// File: rtl/read_return_unit.sv
// Read-return unit: queues read tags and pops DDR read-buffer lines for each tag.
// Lines go out as four 32-bit ring words (low word first) or whole to the display controller.
module read_return_unit (
   input  logic         clock,
   input  logic         reset,
   input  logic         tagWr,
   input  logic [3:0]   tagDest,
   input  logic [1:0]   tagLines,
   output logic         tagFull,
   output logic         tagOverflow,
   input  logic         rbEmpty,
   input  logic [127:0] readData,
   output logic         rdRB,
   output logic [31:0]  RDreturn,
   output logic [3:0]   RDdest,
   output logic [127:0] RDtoDC,
   output logic         wrRDtoDC
);

   typedef enum logic [1:0] {IDLE, SEND, WAITLINE} state_t;

   typedef struct packed {
      logic [3:0] dest;
      logic [1:0] lines;
   } tag_t;

   tag_t         tag_mem [8];
   logic [2:0]   wr_ptr, rd_ptr;
   logic [3:0]   tag_count;
   logic         tag_push, tag_pop, tag_empty, overflow;
   tag_t         head;

   state_t       state, state_n;
   logic [1:0]   wcnt, wcnt_n;
   logic [1:0]   rem, rem_n, rem_cur;
   logic         busy, busy_n;
   logic         dc_last, dc_last_n;
   logic         wr_dc, wr_dc_n;
   logic [127:0] sr, sr_n;

   assign tag_empty   = (tag_count == 4'd0);
   assign tagFull     = (tag_count == 4'd8);
   assign tag_push    = tagWr & (~tagFull | tag_pop);
   assign head        = tag_mem[rd_ptr];
   assign tagOverflow = overflow;
   assign RDtoDC      = sr;
   assign wrRDtoDC    = wr_dc;

   // A display tag spanning several lines stays at the head; busy marks that rem is live.
   assign rem_cur = busy ? rem : head.lines;

   // NOTE: the tag storage is deliberately not reset; only entries between the pointers are ever used.
   always_ff @(posedge clock) begin
      if (tag_push) tag_mem[wr_ptr] <= '{dest: tagDest, lines: tagLines};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (tag_push) wr_ptr <= wr_ptr + 3'd1;
         if (tag_pop)  rd_ptr <= rd_ptr + 3'd1;
         case ({tag_push, tag_pop})
            2'b10:   tag_count <= tag_count + 4'd1;
            2'b01:   tag_count <= tag_count - 4'd1;
            default: tag_count <= tag_count;
         endcase
         if (tagWr && tagFull && !tag_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         rem     <= '0;
         busy    <= 1'b0;
         dc_last <= 1'b0;
         wr_dc   <= 1'b0;
         sr      <= '0;
      end else begin
         state   <= state_n;
         wcnt    <= wcnt_n;
         rem     <= rem_n;
         busy    <= busy_n;
         dc_last <= dc_last_n;
         wr_dc   <= wr_dc_n;
         sr      <= sr_n;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n   = state;
      wcnt_n    = wcnt;
      rem_n     = rem;
      busy_n    = busy;
      dc_last_n = 1'b0;
      wr_dc_n   = 1'b0;
      sr_n      = sr;
      rdRB      = 1'b0;
      tag_pop   = 1'b0;
      RDreturn  = '0;
      RDdest    = '0;

      case (state)
         IDLE: begin
            if (dc_last) begin
               // Last display strobe is out this cycle; retire the tag before fetching again.
               tag_pop = 1'b1;
            end else if (!tag_empty && !rbEmpty) begin
               rdRB = 1'b1;
               sr_n = readData;
               if (head.dest == 4'd0) begin
                  wr_dc_n = 1'b1;
                  if (rem_cur == 2'd0) begin
                     dc_last_n = 1'b1;
                     busy_n    = 1'b0;
                  end else begin
                     rem_n  = rem_cur - 2'd1;
                     busy_n = 1'b1;
                  end
               end else begin
                  state_n = SEND;
                  wcnt_n  = 2'd0;
                  rem_n   = head.lines;
               end
            end
         end

         SEND: begin
            RDreturn = sr[31:0];
            RDdest   = head.dest;
            if (wcnt == 2'd3) begin
               wcnt_n = 2'd0;
               if (rem == 2'd0) begin
                  tag_pop = 1'b1;
                  state_n = IDLE;
               end else if (!rbEmpty) begin
                  rdRB  = 1'b1;
                  sr_n  = readData;
                  rem_n = rem - 2'd1;
               end else begin
                  state_n = WAITLINE;
               end
            end else begin
               wcnt_n = wcnt + 2'd1;
               sr_n   = {32'h0, sr[127:32]};
            end
         end

         WAITLINE: begin
            if (!rbEmpty) begin
               rdRB    = 1'b1;
               sr_n    = readData;
               rem_n   = rem - 2'd1;
               wcnt_n  = 2'd0;
               state_n = SEND;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule
